uart_tx_queue: RTL and testbench

//  Byte queue in front of the UART transmitter. Buffers host bytes in a FIFO and issues one

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_sync_fifo.sv | 54 +++++
 rtl/uart_tx_queue.sv | 146 ++++++++++++++
 tb/tb_uart_tx_queue.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit queue: FSM states and XON/XOFF flow-control bytes.
package uart_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] XON_BYTE  = 8'h11;
  localparam logic [BYTE_W-1:0] XOFF_BYTE = 8'h13;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous byte FIFO with wrap-bit pointers; head word is visible combinationally on rdata.
module uart_sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned W     = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam int unsigned PW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          do_push, do_pop;

  // Full when the wrap bits differ but the index bits match.
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign level   = wr_ptr_q - rd_ptr_q;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding the UART transmitter: one xmitH pulse per byte, paced on xmit_doneH.
// Optional XON/XOFF hold on received bytes is enabled by defining UART_TXQ_XONXOFF_EN.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned AW      = 4,
  parameter int unsigned BUSY_TO = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic              xmitH,
  output logic [BYTE_W-1:0] xmit_dataH,
  input  logic              xmit_doneH,
  output logic [AW:0]       level,
  output logic              tx_busy,
  output logic              launch_err,
  input  logic [BYTE_W-1:0] rx_byte,
  input  logic              rx_valid
);

  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(BUSY_TO) + 1;

  tx_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              xmit_q, xmit_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;
  logic              hold_q, hold_d;

  logic              push_c, pop_c;
  logic [BYTE_W-1:0] fifo_rdata;
  logic              fifo_full, fifo_empty;
  logic [PW-1:0]     fifo_level, level_nxt;

  assign push_c = wr_valid && ready_q;

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (BYTE_W)
  ) u_fifo (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .push  (push_c),
    .wdata (wr_data),
    .pop   (pop_c),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

`ifdef UART_TXQ_XONXOFF_EN
  always_comb begin
    hold_d = hold_q;
    if (rx_valid && (rx_byte == XOFF_BYTE))     hold_d = 1'b1;
    else if (rx_valid && (rx_byte == XON_BYTE)) hold_d = 1'b0;
  end
`else
  logic unused_rx;
  assign unused_rx = ^{rx_byte, rx_valid};
  assign hold_d    = 1'b0;
`endif

  // Launch/handshake sequencing; the FIFO head is popped in the same cycle it is latched.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    xmit_d  = 1'b0;
    data_d  = data_q;
    err_d   = err_q;
    pop_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && xmit_doneH && !hold_q) begin
          pop_c   = 1'b1;
          data_d  = fifo_rdata;
          xmit_d  = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!xmit_doneH) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CW'(BUSY_TO - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_DONE: begin
        if (xmit_doneH) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Status flags are computed from next-cycle occupancy so they stay registered.
  always_comb begin
    level_nxt = fifo_level + PW'(push_c) - PW'(pop_c);
    ready_d   = (level_nxt != PW'(DEPTH));
    busy_d    = (state_d != IDLE) || (level_nxt != '0);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      xmit_q  <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      xmit_q  <= xmit_d;
      data_q  <= data_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      hold_q  <= hold_d;
    end
  end

  assign wr_ready   = ready_q;
  assign xmitH      = xmit_q;
  assign xmit_dataH = data_q;
  assign level      = fifo_level;
  assign tx_busy    = busy_q;
  assign launch_err = err_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: behavioural UART model plus byte-order scoreboard.
module tb_uart_tx_queue;

  localparam int unsigned DEPTH   = 16;
  localparam int unsigned AW      = 4;
  localparam int unsigned BUSY_TO = 8;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic [7:0]    wr_data = 8'h00;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic          xmitH;
  logic [7:0]    xmit_dataH;
  logic          xmit_doneH = 1'b1;
  logic [AW:0]   level;
  logic          tx_busy;
  logic          launch_err;
  logic [7:0]    rx_byte = 8'h00;
  logic          rx_valid = 1'b0;

  int total = 0;
  int bad   = 0;

  // UART model: 0 normal, 1 stalled (done low), 2 unresponsive (done stays high)
  int uart_mode = 0;
  int busy_min  = 3;
  int busy_max  = 8;
  int busy_left = 0;

  int         lvl_m = 0;
  bit         hold_m = 1'b0;
  int         proto_err = 0;
  int         cyc = 0;
  bit         prev_xmit = 1'b0;
  logic [7:0] acc_q[$];
  logic [7:0] got_q[$];

  uart_tx_queue #(.DEPTH(DEPTH), .AW(AW), .BUSY_TO(BUSY_TO)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .xmitH      (xmitH),
    .xmit_dataH (xmit_dataH),
    .xmit_doneH (xmit_doneH),
    .level      (level),
    .tx_busy    (tx_busy),
    .launch_err (launch_err),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid)
  );

  always #5 sys_clk = ~sys_clk;

  // One clock: advance the reference model and the UART model, record launches.
  task automatic tick();
    bit         rst_pre, push_acc, done_pre, hold_pre;
    int         lvl_pre;
    logic [7:0] data_pre;
    rst_pre  = sys_rst;
    done_pre = xmit_doneH;
    hold_pre = hold_m;
    lvl_pre  = lvl_m;
    data_pre = wr_data;
    push_acc = !sys_rst && wr_valid && (lvl_m < int'(DEPTH));
    @(posedge sys_clk);
    #1;
    cyc++;
    if (cyc > 40000) begin
      $display("FAIL watchdog: cycle=%0d required below 40000", cyc);
      $fatal(1);
    end
    if (rst_pre) begin
      lvl_m = 0;
      hold_m = 1'b0;
      acc_q.delete();
      got_q.delete();
      xmit_doneH = 1'b1;
      busy_left = 0;
      prev_xmit = xmitH;
      return;
    end
`ifdef UART_TXQ_XONXOFF_EN
    if (rx_valid && rx_byte == 8'h13) hold_m = 1'b1;
    else if (rx_valid && rx_byte == 8'h11) hold_m = 1'b0;
`endif
    if (push_acc) begin
      acc_q.push_back(data_pre);
      lvl_m++;
    end
    if (xmitH) begin
      if (!done_pre || lvl_pre == 0 || hold_pre || prev_xmit) proto_err++;
      got_q.push_back(xmit_dataH);
      lvl_m--;
    end
    prev_xmit = xmitH;
    case (uart_mode)
      1: xmit_doneH = 1'b0;
      2: xmit_doneH = 1'b1;
      default: begin
        if (xmitH) begin
          xmit_doneH = 1'b0;
          busy_left = int'($urandom_range(busy_max, busy_min));
        end else if (!xmit_doneH) begin
          if (busy_left <= 1) xmit_doneH = 1'b1;
          else busy_left--;
        end
      end
    endcase
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((lvl_m != 0 || tx_busy !== 1'b0) && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    tick();
    tick();
    sys_rst = 1'b0;
    total++; if (level !== 5'd0)       begin bad++; $display("FAIL reset_level: got %0d want 0", level); end
    total++; if (wr_ready !== 1'b1)    begin bad++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
    total++; if (xmitH !== 1'b0)       begin bad++; $display("FAIL reset_xmitH: got %b want 0", xmitH); end
    total++; if (xmit_dataH !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", xmit_dataH); end
    total++; if (tx_busy !== 1'b0)     begin bad++; $display("FAIL reset_tx_busy: got %b want 0", tx_busy); end
    total++; if (launch_err !== 1'b0)  begin bad++; $display("FAIL reset_launch_err: got %b want 0", launch_err); end
  endtask

  task automatic test_single();
    uart_mode = 0;
    got_q.delete(); acc_q.delete();
    wr_data = 8'hA5; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    total++; if (level !== 5'd1) begin bad++; $display("FAIL single_level_after_push: got %0d want 1", level); end
    total++; if (xmitH !== 1'b0) begin bad++; $display("FAIL single_no_bypass: got xmitH=%b want 0", xmitH); end
    tick();
    total++; if (xmitH !== 1'b1)       begin bad++; $display("FAIL single_launch: got xmitH=%b want 1", xmitH); end
    total++; if (xmit_dataH !== 8'hA5) begin bad++; $display("FAIL single_data: got %h want a5", xmit_dataH); end
    total++; if (level !== 5'd0)       begin bad++; $display("FAIL single_level_after_pop: got %0d want 0", level); end
    tick();
    total++; if (xmitH !== 1'b0) begin bad++; $display("FAIL single_pulse_width: got xmitH=%b want 0", xmitH); end
    drain(200);
    total++; if (xmit_dataH !== 8'hA5) begin bad++; $display("FAIL single_data_hold: got %h want a5", xmit_dataH); end
  endtask

  task automatic test_fill();
    int mism = 0;
    got_q.delete(); acc_q.delete();
    uart_mode = 1;
    xmit_doneH = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wr_data = 8'(i); wr_valid = 1'b1;
      tick();
    end
    total++; if (level !== 5'd16)   begin bad++; $display("FAIL fill_level: got %0d want 16", level); end
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL fill_wr_ready: got %b want 0", wr_ready); end
    wr_data = 8'h10; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    total++; if (level !== 5'd16) begin bad++; $display("FAIL fill_drop17: got level %0d want 16", level); end
    uart_mode = 0;
    xmit_doneH = 1'b1;
    drain(600);
    for (int i = 0; i < 16; i++)
      if (i >= got_q.size() || got_q[i] !== 8'(i)) mism++;
    total++; if (got_q.size() != 16 || mism != 0)
      begin bad++; $display("FAIL fill_drain_order: got %0d launches, %0d wrong, want 16 in order 00..0f", got_q.size(), mism); end
  endtask

  task automatic test_simul();
    int mism = 0;
    int lvl_bad = 0;
    int n = 0;
    got_q.delete(); acc_q.delete();
    uart_mode = 1;
    xmit_doneH = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_data = 8'($urandom); wr_valid = 1'b1;
      tick();
    end
    total++; if (level !== 5'd3) begin bad++; $display("FAIL simul_pre_level: got %0d want 3", level); end
    uart_mode = 0;
    xmit_doneH = 1'b1;
    wr_data = 8'($urandom); wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    total++; if (xmitH !== 1'b1) begin bad++; $display("FAIL simul_pop: got xmitH=%b want 1", xmitH); end
    total++; if (level !== 5'd3) begin bad++; $display("FAIL simul_level: got %0d want 3", level); end
    busy_min = 3; busy_max = 5;
    while (acc_q.size() < 44 && n < 4000) begin
      wr_valid = ($urandom_range(3, 0) != 0);
      wr_data  = 8'($urandom);
      tick();
      if (int'(level) != lvl_m) lvl_bad++;
      n++;
    end
    wr_valid = 1'b0;
    drain(2000);
    busy_min = 3; busy_max = 8;
    for (int i = 0; i < acc_q.size(); i++)
      if (i >= got_q.size() || got_q[i] !== acc_q[i]) mism++;
    total++; if (lvl_bad != 0) begin bad++; $display("FAIL wrap_level_track: got %0d level mismatches want 0", lvl_bad); end
    total++; if (got_q.size() != acc_q.size() || mism != 0 || acc_q.size() < 44)
      begin bad++; $display("FAIL wrap_data: got %0d launches %0d wrong, want %0d (>=44) in order", got_q.size(), mism, acc_q.size()); end
  endtask

  task automatic test_timeout();
    int k = 0;
    got_q.delete(); acc_q.delete();
    uart_mode = 2;
    xmit_doneH = 1'b1;
    wr_data = 8'h5A; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    tick();
    total++; if (xmitH !== 1'b1) begin bad++; $display("FAIL timeout_launch: got xmitH=%b want 1", xmitH); end
    while (launch_err !== 1'b1 && k < 30) begin
      tick();
      k++;
    end
    total++; if (k != 9) begin bad++; $display("FAIL timeout_cycles: got err after %0d cycles want 9", k); end
    total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL timeout_idle: got tx_busy=%b want 0", tx_busy); end
    uart_mode = 0;
    wr_data = 8'hC3; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    tick();
    total++; if (xmitH !== 1'b1 || xmit_dataH !== 8'hC3)
      begin bad++; $display("FAIL timeout_next_launch: got xmitH=%b data=%h want 1/c3", xmitH, xmit_dataH); end
    drain(200);
    total++; if (launch_err !== 1'b1) begin bad++; $display("FAIL timeout_sticky: got %b want 1", launch_err); end
  endtask

  task automatic test_xonxoff();
    int mism = 0;
    got_q.delete(); acc_q.delete();
    uart_mode = 0;
    busy_min = 6; busy_max = 6;
    wr_data = 8'h21; wr_valid = 1'b1;
    tick();
    wr_data = 8'h22;
    tick();
    wr_valid = 1'b0;
    total++; if (xmitH !== 1'b1) begin bad++; $display("FAIL xon_first_launch: got xmitH=%b want 1", xmitH); end
    rx_byte = 8'h13; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
`ifdef UART_TXQ_XONXOFF_EN
    total++; if (got_q.size() != 1 || level !== 5'd1)
      begin bad++; $display("FAIL xoff_hold: got %0d launches level %0d want 1/1", got_q.size(), level); end
    rx_byte = 8'h11; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick();
    total++; if (xmitH !== 1'b1 || xmit_dataH !== 8'h22)
      begin bad++; $display("FAIL xon_resume: got xmitH=%b data=%h want 1/22", xmitH, xmit_dataH); end
`else
    total++; if (got_q.size() != 2 || level !== 5'd0)
      begin bad++; $display("FAIL xoff_ignored: got %0d launches level %0d want 2/0", got_q.size(), level); end
    rx_byte = 8'h11; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick();
    total++; if (xmitH !== 1'b0) begin bad++; $display("FAIL xon_ignored: got xmitH=%b want 0", xmitH); end
`endif
    drain(300);
    busy_min = 3; busy_max = 8;
    for (int i = 0; i < acc_q.size(); i++)
      if (i >= got_q.size() || got_q[i] !== acc_q[i]) mism++;
    total++; if (got_q.size() != 2 || mism != 0)
      begin bad++; $display("FAIL xon_order: got %0d launches %0d wrong want 2 in order", got_q.size(), mism); end
  endtask

  task automatic test_reset_mid();
    uart_mode = 0;
    busy_min = 20; busy_max = 20;
    for (int i = 0; i < 6; i++) begin
      wr_data = 8'($urandom); wr_valid = 1'b1;
      tick();
    end
    wr_valid = 1'b0;
    total++; if (level !== 5'd5 || tx_busy !== 1'b1)
      begin bad++; $display("FAIL rstmid_pre: got level %0d busy %b want 5/1", level, tx_busy); end
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    busy_min = 3; busy_max = 8;
    total++; if (level !== 5'd0)      begin bad++; $display("FAIL rstmid_level: got %0d want 0", level); end
    total++; if (xmitH !== 1'b0)      begin bad++; $display("FAIL rstmid_xmitH: got %b want 0", xmitH); end
    total++; if (tx_busy !== 1'b0)    begin bad++; $display("FAIL rstmid_tx_busy: got %b want 0", tx_busy); end
    total++; if (launch_err !== 1'b0) begin bad++; $display("FAIL rstmid_err_clear: got %b want 0", launch_err); end
    for (int i = 0; i < 5; i++) tick();
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL rstmid_no_launch: got %0d launches want 0", got_q.size()); end
  endtask

  task automatic test_protocol();
    total++; if (proto_err != 0) begin bad++; $display("FAIL launch_protocol: got %0d illegal launches want 0", proto_err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_simul();
    test_timeout();
    test_xonxoff();
    test_reset_mid();
    test_protocol();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
